// File: rtl/key_stage_pkg.sv
// rtl/key_stage_pkg.sv - shared state encodings and combine-mode constants
// Purpose: state numbering helpers for the stage sequencer and the MODE encoding.
// Ports: none (package).
package key_stage_pkg;

  // Counting stages occupy codes 0..NUM_CH-1; COMPUTE and SHOW follow them.
  localparam int ST_COUNT_BASE = 0;

  function automatic int st_compute(input int num_ch);
    return ST_COUNT_BASE + num_ch;
  endfunction

  function automatic int st_show(input int num_ch);
    return ST_COUNT_BASE + num_ch + 1;
  endfunction

  function automatic int state_w(input int num_ch);
    return $clog2(num_ch + 2);
  endfunction

  typedef enum logic [1:0] {
    MODE_MUL = 2'd0,
    MODE_SUM = 2'd1,
    MODE_MAX = 2'd2,
    MODE_XOR = 2'd3
  } mode_e;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchroniser, debouncer and press detector for one key
// Purpose: turns a raw active-low button into a one-cycle press pulse.
// Ports:
//   CLOCK_50    in  clock
//   RESET       in  synchronous active-high reset
//   key_n       in  raw asynchronous active-low key
//   press_pulse out one-cycle pulse on an accepted 1-to-0 transition
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic key_n,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic          armed;
  logic [CW-1:0] cnt;

  // The synchroniser resets to 0 ("possibly pressed") and the debouncer stays
  // disarmed until it sees a released sample, so a key held through reset
  // never produces a pulse until it has been released and pressed again.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync_1      <= 1'b0;
      sync_2      <= 1'b0;
      level       <= 1'b1;
      armed       <= 1'b0;
      cnt         <= RELOAD;
      press_pulse <= 1'b0;
    end else begin
      sync_1      <= key_n;
      sync_2      <= sync_1;
      press_pulse <= 1'b0;
      if (!armed) begin
        armed <= sync_2;
        cnt   <= RELOAD;
      end else if (sync_2 == level) begin
        cnt <= RELOAD;
      end else if (cnt == '0) begin
        level       <= sync_2;
        cnt         <= RELOAD;
        press_pulse <= ~sync_2;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/key_stage_accumulator.sv
// rtl/key_stage_accumulator.sv - key-driven stage sequencer with counter combine
// Purpose: KEY[0] steps through NUM_CH counting stages, a COMPUTE phase and a
// SHOW phase; KEY[1] counts in the active stage or clears all counters in SHOW.
// Ports:
//   CLOCK_50 in  clock
//   RESET    in  synchronous active-high reset
//   KEY      in  raw active-low keys, [0] = step, [1] = count/clear
//   MODE     in  combine mode (product, sum, max, xor)
//   LED      out registered display
//   BUSY     out high while computing
module key_stage_accumulator
  import key_stage_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int CNT_W           = 8,
  parameter int LED_W           = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [1:0]       KEY,
  input  logic [1:0]       MODE,
  output logic [LED_W-1:0] LED,
  output logic             BUSY
);

  localparam int SW = state_w(NUM_CH);
  localparam logic [SW-1:0] S_COUNT0  = SW'(ST_COUNT_BASE);
  localparam logic [SW-1:0] S_COMPUTE = SW'(st_compute(NUM_CH));
  localparam logic [SW-1:0] S_SHOW    = SW'(st_show(NUM_CH));
  localparam logic [SW-1:0] LAST_IDX  = SW'(NUM_CH - 1);

  logic             step_p;
  logic             count_p;
  logic [SW-1:0]    state;
  logic [SW-1:0]    state_next;
  logic [SW-1:0]    idx;
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [CNT_W-1:0] sel_cnt;
  logic [LED_W-1:0] operand;
  logic [LED_W-1:0] acc;
  logic [LED_W-1:0] fold;
  logic [LED_W-1:0] led_next;
  mode_e            mode_q;
  logic             is_count;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_key (
    .CLOCK_50    (CLOCK_50),
    .RESET       (RESET),
    .key_n       (KEY[0]),
    .press_pulse (step_p)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_count_key (
    .CLOCK_50    (CLOCK_50),
    .RESET       (RESET),
    .key_n       (KEY[1]),
    .press_pulse (count_p)
  );

  assign is_count = (state < S_COMPUTE);
  assign BUSY     = (state == S_COMPUTE);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) state <= S_COUNT0;
    else       state <= state_next;
  end

  // COUNT_{NUM_CH-1} + 1 is exactly the COMPUTE code, so one increment covers
  // every counting-stage step.
  always_comb begin
    state_next = state;
    if (is_count) begin
      if (step_p) state_next = state + SW'(1);
    end else if (state == S_COMPUTE) begin
      if (idx == LAST_IDX) state_next = S_SHOW;
    end else begin
      if (step_p) state_next = S_COUNT0;
    end
  end

  always_comb begin
    sel_cnt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx == SW'(k)) sel_cnt = cnt[k];
    end
  end

  assign operand = LED_W'(sel_cnt);

  always_comb begin
    fold = acc;
    case (mode_q)
      MODE_MUL: fold = acc * operand;
      MODE_SUM: fold = acc + operand;
      MODE_MAX: fold = (acc > operand) ? acc : operand;
      MODE_XOR: fold = acc ^ operand;
      default:  fold = acc;
    endcase
  end

  always_comb begin
    led_next = LED;
    if (is_count)              led_next = ~({LED_W{1'b1}} << (int'(state) + 1));
    else if (state == S_SHOW)  led_next = acc;
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
      acc    <= '0;
      mode_q <= MODE_MUL;
      idx    <= '0;
      LED    <= LED_W'(1);
    end else begin
      LED <= led_next;
      if (is_count) begin
        idx <= '0;
        for (int k = 0; k < NUM_CH; k++) begin
          if (count_p && state == SW'(k)) cnt[k] <= cnt[k] + CNT_W'(1);
        end
      end else if (state == S_COMPUTE) begin
        // First COMPUTE cycle loads cnt[0] and captures MODE; later cycles fold.
        if (idx == '0) begin
          acc    <= operand;
          mode_q <= mode_e'(MODE);
        end else begin
          acc <= fold;
        end
        idx <= idx + SW'(1);
      end else begin
        idx <= '0;
        if (count_p) begin
          for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
        end
      end
    end
  end

endmodule
